// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write/read port bundle for the multi-port register file
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     WE0;
    logic [ADDR_W-1:0]        Rw0;
    logic [DATA_W/8-1:0]      BE0;
    logic [DATA_W-1:0]        busW0;
    logic                     WE1;
    logic [ADDR_W-1:0]        Rw1;
    logic [DATA_W/8-1:0]      BE1;
    logic [DATA_W-1:0]        busW1;
    logic [NUM_RD*ADDR_W-1:0] Ra;
    logic [NUM_RD*DATA_W-1:0] busR;

    modport master (
        output WE0, Rw0, BE0, busW0,
        output WE1, Rw1, BE1, busW1,
        output Ra,
        input  busR
    );

    modport slave (
        input  WE0, Rw0, BE0, busW0,
        input  WE1, Rw1, BE1, busW1,
        input  Ra,
        output busR
    );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised register file, NUM_RD comb reads, two byte-enabled writes
module reg_file_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RESET_INIT = 0
) (
    input  logic          CLK,
    input  logic          RST,
    reg_file_mp_if.slave  bus
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] nxt  [NUM_REGS];
    logic [ADDR_W-1:0] ra_k [NUM_RD];

    // nxt is the post-edge image of every register; it feeds both the commit and the bypass,
    // so forwarding and writing can never disagree on priority or discard rules.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            nxt[i] = regs[i];
            if (!(ZERO_REG != 0 && i == 0)) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.WE1 && bus.Rw1 == ADDR_W'(i) && bus.BE1[b]) begin
                        nxt[i][b*8 +: 8] = bus.busW1[b*8 +: 8];
                    end else if (bus.WE0 && bus.Rw0 == ADDR_W'(i) && bus.BE0[b]) begin
                        nxt[i][b*8 +: 8] = bus.busW0[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (RESET_INIT != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= nxt[i];
            end
        end
    end

    always_comb begin
        bus.busR = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_k[k] = bus.Ra[k*ADDR_W +: ADDR_W];
            if (!RST && int'(ra_k[k]) < NUM_REGS && !(ZERO_REG != 0 && ra_k[k] == '0)) begin
                bus.busR[k*DATA_W +: DATA_W] = (BYPASS != 0) ? nxt[ra_k[k]] : regs[ra_k[k]];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed bench for reg_file_mp in two parameter configurations
module tb_reg_file_mp;
    logic CLK;
    logic RST;
    int   checks;
    int   fails;

    // A: 32 regs, zero reg, bypass, reset loads index. B: 24 regs, no zero reg, no bypass, reset clears.
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ib ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2),
                  .ZERO_REG(1), .BYPASS(1), .RESET_INIT(1))
        dut_a (.CLK(CLK), .RST(RST), .bus(ia));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .NUM_RD(2),
                  .ZERO_REG(0), .BYPASS(0), .RESET_INIT(0))
        dut_b (.CLK(CLK), .RST(RST), .bus(ib));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic we0, input logic [4:0] rw0, input logic [3:0] be0,
                         input logic [31:0] w0, input logic we1, input logic [4:0] rw1,
                         input logic [3:0] be1, input logic [31:0] w1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        ia.WE0 = we0; ia.Rw0 = rw0; ia.BE0 = be0; ia.busW0 = w0;
        ia.WE1 = we1; ia.Rw1 = rw1; ia.BE1 = be1; ia.busW1 = w1;
        ia.Ra  = {ra1, ra0};
        ib.WE0 = we0; ib.Rw0 = rw0; ib.BE0 = be0; ib.busW0 = w0;
        ib.WE1 = we1; ib.Rw1 = rw1; ib.BE1 = be1; ib.busW1 = w1;
        ib.Ra  = {ra1, ra0};
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        @(negedge CLK);
        checks++; if (ia.busR !== 64'h0) begin fails++; $display("FAIL reset_hold_a got %h want %h", ia.busR, 64'h0); end
        checks++; if (ib.busR !== 64'h0) begin fails++; $display("FAIL reset_hold_b got %h want %h", ib.busR, 64'h0); end
        next_cycle();
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 31);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'd7) begin fails++; $display("FAIL reset_init_a7 got %h want %h", ia.busR[31:0], 32'd7); end
        checks++; if (ia.busR[63:32] !== 32'd31) begin fails++; $display("FAIL reset_init_a31 got %h want %h", ia.busR[63:32], 32'd31); end
        checks++; if (ib.busR[31:0] !== 32'd0) begin fails++; $display("FAIL reset_clear_b got %h want %h", ib.busR[31:0], 32'd0); end
        checks++; if (ib.busR[63:32] !== 32'd0) begin fails++; $display("FAIL range_read_b31 got %h want %h", ib.busR[63:32], 32'd0); end
    endtask

    task automatic test_write_read();
        next_cycle();
        drive(1, 5, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bypass_a got %h want %h", ia.busR[31:0], 32'hDEADBEEF); end
        checks++; if (ib.busR[31:0] !== 32'h0) begin fails++; $display("FAIL wr_nobypass_b got %h want %h", ib.busR[31:0], 32'h0); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        @(negedge CLK);
        checks++; if (ia.busR[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_commit_a got %h want %h", ia.busR[63:32], 32'hDEADBEEF); end
        checks++; if (ib.busR[63:32] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_commit_b got %h want %h", ib.busR[63:32], 32'hDEADBEEF); end
    endtask

    task automatic test_collision();
        next_cycle();
        drive(1, 3, 4'hF, 32'h11223344, 1, 3, 4'h3, 32'hAABBCCDD, 3, 3);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'h1122CCDD) begin fails++; $display("FAIL coll_bypass_a got %h want %h", ia.busR[31:0], 32'h1122CCDD); end
        checks++; if (ib.busR[31:0] !== 32'h0) begin fails++; $display("FAIL coll_old_b got %h want %h", ib.busR[31:0], 32'h0); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        @(negedge CLK);
        checks++; if (ia.busR[63:32] !== 32'h1122CCDD) begin fails++; $display("FAIL coll_commit_a got %h want %h", ia.busR[63:32], 32'h1122CCDD); end
        checks++; if (ib.busR[63:32] !== 32'h1122CCDD) begin fails++; $display("FAIL coll_commit_b got %h want %h", ib.busR[63:32], 32'h1122CCDD); end
    endtask

    task automatic test_byte_merge();
        next_cycle();
        drive(1, 6, 4'hF, 32'h66666666, 1, 5, 4'h8, 32'h55000000, 5, 6);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'h55ADBEEF) begin fails++; $display("FAIL be_bypass_a5 got %h want %h", ia.busR[31:0], 32'h55ADBEEF); end
        checks++; if (ia.busR[63:32] !== 32'h66666666) begin fails++; $display("FAIL be_bypass_a6 got %h want %h", ia.busR[63:32], 32'h66666666); end
        checks++; if (ib.busR[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL be_old_b5 got %h want %h", ib.busR[31:0], 32'hDEADBEEF); end
        next_cycle();
        drive(1, 7, 4'hF, 32'h77777777, 0, 0, 0, 0, 5, 6);
        @(negedge CLK);
        checks++; if (ib.busR[31:0] !== 32'h55ADBEEF) begin fails++; $display("FAIL be_commit_b5 got %h want %h", ib.busR[31:0], 32'h55ADBEEF); end
        checks++; if (ib.busR[63:32] !== 32'h66666666) begin fails++; $display("FAIL be_commit_b6 got %h want %h", ib.busR[63:32], 32'h66666666); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'h77777777) begin fails++; $display("FAIL be_commit_a7 got %h want %h", ia.busR[31:0], 32'h77777777); end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 4'hF, 32'hFFFFFFFF, 0, 0);
        @(negedge CLK);
        checks++; if (ia.busR !== 64'h0) begin fails++; $display("FAIL zero_same_a got %h want %h", ia.busR, 64'h0); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'h0) begin fails++; $display("FAIL zero_after_a got %h want %h", ia.busR[31:0], 32'h0); end
        checks++; if (ib.busR[31:0] !== 32'hFFFFFFFF) begin fails++; $display("FAIL reg0_plain_b got %h want %h", ib.busR[31:0], 32'hFFFFFFFF); end
    endtask

    task automatic test_range();
        next_cycle();
        drive(1, 30, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0, 30, 6);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'hCAFEF00D) begin fails++; $display("FAIL range_bypass_a got %h want %h", ia.busR[31:0], 32'hCAFEF00D); end
        checks++; if (ib.busR[31:0] !== 32'h0) begin fails++; $display("FAIL range_same_b got %h want %h", ib.busR[31:0], 32'h0); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 30, 6);
        @(negedge CLK);
        checks++; if (ib.busR[31:0] !== 32'h0) begin fails++; $display("FAIL range_after_b got %h want %h", ib.busR[31:0], 32'h0); end
        checks++; if (ib.busR[63:32] !== 32'h66666666) begin fails++; $display("FAIL range_alias_b6 got %h want %h", ib.busR[63:32], 32'h66666666); end
        checks++; if (ia.busR[31:0] !== 32'hCAFEF00D) begin fails++; $display("FAIL range_commit_a got %h want %h", ia.busR[31:0], 32'hCAFEF00D); end
    endtask

    task automatic test_reset_mid_write();
        next_cycle();
        RST = 1'b1;
        drive(1, 9, 4'hF, 32'h99999999, 0, 0, 0, 0, 9, 5);
        @(negedge CLK);
        checks++; if (ia.busR !== 64'h0) begin fails++; $display("FAIL rstwr_bypass_a got %h want %h", ia.busR, 64'h0); end
        checks++; if (ib.busR !== 64'h0) begin fails++; $display("FAIL rstwr_hold_b got %h want %h", ib.busR, 64'h0); end
        next_cycle();
        RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 5);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'd9) begin fails++; $display("FAIL rstwr_reg9_a got %h want %h", ia.busR[31:0], 32'd9); end
        checks++; if (ia.busR[63:32] !== 32'd5) begin fails++; $display("FAIL rstwr_reg5_a got %h want %h", ia.busR[63:32], 32'd5); end
        checks++; if (ib.busR !== 64'h0) begin fails++; $display("FAIL rstwr_regs_b got %h want %h", ib.busR, 64'h0); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive(1, 10, 4'h1, 32'h000000AA, 0, 0, 0, 0, 10, 10);
        @(negedge CLK);
        checks++; if (ia.busR[31:0] !== 32'h000000AA) begin fails++; $display("FAIL b2b_first_a got %h want %h", ia.busR[31:0], 32'h000000AA); end
        checks++; if (ib.busR[31:0] !== 32'h0) begin fails++; $display("FAIL b2b_first_b got %h want %h", ib.busR[31:0], 32'h0); end
        next_cycle();
        drive(1, 10, 4'h2, 32'h0000BB00, 0, 0, 0, 0, 10, 10);
        @(negedge CLK);
        checks++; if (ia.busR[63:32] !== 32'h0000BBAA) begin fails++; $display("FAIL b2b_second_a got %h want %h", ia.busR[63:32], 32'h0000BBAA); end
        checks++; if (ib.busR[63:32] !== 32'h000000AA) begin fails++; $display("FAIL b2b_second_b got %h want %h", ib.busR[63:32], 32'h000000AA); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 10);
        @(negedge CLK);
        checks++; if (ib.busR[31:0] !== 32'h0000BBAA) begin fails++; $display("FAIL b2b_commit_b got %h want %h", ib.busR[31:0], 32'h0000BBAA); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        RST    = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_write_read();
        test_collision();
        test_byte_merge();
        test_zero_reg();
        test_range();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
